aes_pnm_block_sequencer: RTL and testbench

Host-side sequencer that sits directly upstream of the AES near-memory top and consumes its results. It accepts 128-bit blocks over a valid/ready stream and loads each one into FeRAM through the state-init port. It then pulses start, waits for done, captures the final state, and returns it over a valid/ready output stream. Enc/dec mode travels with each block and is held stable at the core for the block's whole lifetime.

---
 rtl/aes_pnm_block_sequencer_if.sv | 47 ++++
 rtl/aes_pnm_block_sequencer.sv | 160 ++++++++++++++++
 tb/tb_aes_pnm_block_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_pnm_block_sequencer_if.sv
// Stream and core-side signal bundle for aes_pnm_block_sequencer.
// slave  : the sequencer's view.
// master : the host/core-environment view.
// timeout_err exists only when AES_PNM_SEQ_TIMEOUT_EN is defined.
interface aes_pnm_block_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_block;
  logic             in_enc_dec;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_block;
  logic             out_enc_dec;
  logic [127:0]     core_state_init;
  logic             core_state_init_en;
  logic             core_start;
  logic             core_enc_dec;
  logic             core_done;
  logic [127:0]     core_state_out;
  logic             busy;
  logic [CNT_W-1:0] blk_count;
`ifdef AES_PNM_SEQ_TIMEOUT_EN
  logic             timeout_err;
`endif

  modport slave (
    input  in_valid, in_block, in_enc_dec, out_ready, core_done, core_state_out,
    output in_ready, out_valid, out_block, out_enc_dec,
           core_state_init, core_state_init_en, core_start, core_enc_dec,
           busy, blk_count
`ifdef AES_PNM_SEQ_TIMEOUT_EN
    , output timeout_err
`endif
  );

  modport master (
    output in_valid, in_block, in_enc_dec, out_ready, core_done, core_state_out,
    input  in_ready, out_valid, out_block, out_enc_dec,
           core_state_init, core_state_init_en, core_start, core_enc_dec,
           busy, blk_count
`ifdef AES_PNM_SEQ_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/aes_pnm_block_sequencer.sv
// Host-side sequencer for the AES near-memory core: accepts a 128-bit block,
// loads it through the state-init port, pulses start, waits for done and
// returns the final state through a single-entry output register.
// Optional feature macro: AES_PNM_SEQ_TIMEOUT_EN (WAIT watchdog + timeout_err).
//
// state   | meaning
// IDLE    | ready for a new block (result may still be draining)
// LOAD    | core_state_init_en high for LOAD_BEATS cycles
// GAP     | enable low for GAP_CYCLES cycles, re-arms core init logic
// START   | core_start high for this one cycle
// WAIT    | waiting for core_done and a free output register
module aes_pnm_block_sequencer #(
  parameter int LOAD_BEATS  = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  aes_pnm_block_sequencer_if.slave bus
);

  // one shared down-counter serves LOAD, GAP and the WAIT watchdog
  localparam int MAX_LG = (LOAD_BEATS > GAP_CYCLES) ? LOAD_BEATS : GAP_CYCLES;
  localparam int MAX_C  = (MAX_LG > TIMEOUT_CYC) ? MAX_LG : TIMEOUT_CYC;
  localparam int CW     = $clog2(MAX_C + 1) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_START, S_WAIT} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             done_seen_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [127:0]     out_block_q;
  logic             out_enc_dec_q;
  logic [127:0]     init_q;
  logic             init_en_q;
  logic             start_q;
  logic             enc_q;
  logic             busy_q;
  logic [CNT_W-1:0] blk_count_q;
`ifdef AES_PNM_SEQ_TIMEOUT_EN
  logic             timeout_q;
`endif

  logic out_free;
  logic done_any;
  assign out_free = !out_valid_q || bus.out_ready;
  assign done_any = done_seen_q || bus.core_done;

  // sequencing FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      done_seen_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_block_q   <= '0;
      out_enc_dec_q <= 1'b0;
      init_q        <= '0;
      init_en_q     <= 1'b0;
      start_q       <= 1'b0;
      enc_q         <= 1'b0;
      busy_q        <= 1'b0;
      blk_count_q   <= '0;
`ifdef AES_PNM_SEQ_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      // drain handshake; a same-cycle capture below re-sets out_valid
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        blk_count_q <= blk_count_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            init_q     <= bus.in_block;
            enc_q      <= bus.in_enc_dec;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= CW'(LOAD_BEATS);
            state_q    <= S_LOAD;
`ifdef AES_PNM_SEQ_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cnt_q != '0) begin
            init_en_q <= 1'b1;
            cnt_q     <= cnt_q - 1'b1;
          end else begin
            init_en_q <= 1'b0;
            cnt_q     <= CW'(GAP_CYCLES - 1);
            state_q   <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            start_q <= 1'b1;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_START: begin
          start_q     <= 1'b0;
          done_seen_q <= 1'b0;
          cnt_q       <= CW'(TIMEOUT_CYC);
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.core_done) done_seen_q <= 1'b1;
          if (done_any && out_free) begin
            out_block_q   <= bus.core_state_out;
            out_enc_dec_q <= enc_q;
            out_valid_q   <= 1'b1;
            done_seen_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
`ifdef AES_PNM_SEQ_TIMEOUT_EN
          else if (!done_any) begin
            if (cnt_q <= CW'(1)) begin
              timeout_q  <= 1'b1;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid_q;
  assign bus.out_block          = out_block_q;
  assign bus.out_enc_dec        = out_enc_dec_q;
  assign bus.core_state_init    = init_q;
  assign bus.core_state_init_en = init_en_q;
  assign bus.core_start         = start_q;
  assign bus.core_enc_dec       = enc_q;
  assign bus.busy               = busy_q;
  assign bus.blk_count          = blk_count_q;
`ifdef AES_PNM_SEQ_TIMEOUT_EN
  assign bus.timeout_err        = timeout_q;
`endif

endmodule

// File: tb/tb_aes_pnm_block_sequencer.sv
// Directed bench for aes_pnm_block_sequencer with a small core model that
// answers each start pulse with done after a programmable delay.
module tb_aes_pnm_block_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  int           done_dly;
  logic [127:0] done_val;
  int           cd;

  localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] R1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] JK = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  localparam logic [127:0] B2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] R2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] B3 = 128'hcafef00d_cafef00d_cafef00d_cafef00d;
  localparam logic [127:0] R3 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] B4 = 128'h12345678_9abcdef0_12345678_9abcdef0;
  localparam logic [127:0] R4 = 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc;

  aes_pnm_block_sequencer_if #(.CNT_W(16)) bus ();

  aes_pnm_block_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // core model: done pulses done_dly cycles after start, state_out held afterwards
  initial begin
    bus.core_done      = 1'b0;
    bus.core_state_out = '0;
    cd = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.core_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.core_done      = 1'b1;
          bus.core_state_out = done_val;
        end
      end
      if (bus.core_start) cd = done_dly;
    end
  end

  // hard stop in case something wedges outside the bounded loops
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int en_cnt, st_cnt, st_at, rdy_seen, chg, ov_at, ov_seen;
    bit found;

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_block   = '0;
    bus.in_enc_dec = 1'b0;
    bus.out_ready  = 1'b1;
    done_dly       = 20;
    done_val       = R1;

    // reset state
    tick(); tick();
    chk("rst_in_ready",  bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_blk_count", bus.blk_count, 0);
    chk("rst_init_en",   bus.core_state_init_en, 0);
    chk("rst_start",     bus.core_start, 0);
    chk("rst_init",      bus.core_state_init, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", bus.in_ready, 1);

    // single encrypt, plus input stall during LOAD
    bus.in_valid = 1'b1; bus.in_block = B1; bus.in_enc_dec = 1'b1;
    tick();
    chk("t1_busy",    bus.busy, 1);
    chk("t1_init",    bus.core_state_init, B1);
    chk("t1_enc",     bus.core_enc_dec, 1);
    chk("t1_init_en0", bus.core_state_init_en, 0);
    bus.in_block = JK; bus.in_enc_dec = 1'b0;
    en_cnt = 0; st_cnt = 0; st_at = 0; rdy_seen = 0; chg = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.core_state_init_en) en_cnt++;
      if (bus.core_start) begin st_cnt++; st_at = i; end
      if (bus.in_ready) rdy_seen++;
      if (bus.core_state_init !== B1 || bus.core_enc_dec !== 1'b1) chg++;
    end
    bus.in_valid = 1'b0;
    chk("t1_en_beats",  32'(en_cnt), 4);
    chk("t1_start_cnt", 32'(st_cnt), 1);
    chk("t1_start_at",  32'(st_at), 6);
    chk("t1_stall_rdy", 32'(rdy_seen), 0);
    chk("t1_stall_chg", 32'(chg), 0);
    ov_at = 0;
    for (int i = 9; i <= 60; i++) begin
      tick();
      if (bus.out_valid) begin ov_at = i; break; end
    end
    chk("t1_ov_at",     32'(ov_at), 27);
    chk("t1_out_block", bus.out_block, R1);
    chk("t1_out_enc",   bus.out_enc_dec, 1);
    chk("t1_in_ready",  bus.in_ready, 1);
    chk("t1_busy_done", bus.busy, 0);
    tick();
    chk("t1_blk_count", bus.blk_count, 1);
    chk("t1_ov_clear",  bus.out_valid, 0);

    // decrypt with back-pressure, second block overlaps drain
    bus.out_ready = 1'b0; done_dly = 5; done_val = R2;
    bus.in_valid = 1'b1; bus.in_block = B2; bus.in_enc_dec = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    chk("t2_init", bus.core_state_init, B2);
    chk("t2_enc",  bus.core_enc_dec, 0);
    ov_at = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.out_valid) begin ov_at = i; break; end
    end
    chk("t2_ov_at",     32'(ov_at), 12);
    chk("t2_out_block", bus.out_block, R2);
    chk("t2_out_enc",   bus.out_enc_dec, 0);
    chk("t2_core_enc",  bus.core_enc_dec, 0);
    chk("t2_in_ready",  bus.in_ready, 1);
    done_val = R3;
    bus.in_valid = 1'b1; bus.in_block = B3; bus.in_enc_dec = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t3_init",       bus.core_state_init, B3);
    chk("t3_ov_pending", bus.out_valid, 1);
    chk("t3_hold_r2",    bus.out_block, R2);
    for (int i = 0; i < 30; i++) tick();
    chk("t3_stall_busy",  bus.busy, 1);
    chk("t3_stall_blk",   bus.out_block, R2);
    chk("t3_stall_count", bus.blk_count, 1);
    chk("t3_core_enc",    bus.core_enc_dec, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("t3_simul_ov",    bus.out_valid, 1);
    chk("t3_simul_blk",   bus.out_block, R3);
    chk("t3_simul_enc",   bus.out_enc_dec, 1);
    chk("t3_simul_count", bus.blk_count, 2);
    chk("t3_simul_busy",  bus.busy, 0);
    tick();
    chk("t3_final_count", bus.blk_count, 3);
    chk("t3_final_ov",    bus.out_valid, 0);

    // reset three cycles into WAIT
    done_dly = 20; done_val = R4;
    bus.in_valid = 1'b1; bus.in_block = B4; bus.in_enc_dec = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.core_start) begin found = 1'b1; break; end
    end
    chk("t4_start_seen", found, 1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ov",    bus.out_valid, 0);
    chk("t4_rst_busy",  bus.busy, 0);
    chk("t4_rst_rdy",   bus.in_ready, 0);
    chk("t4_rst_init",  bus.core_state_init, 0);
    chk("t4_rst_enc",   bus.core_enc_dec, 0);
    chk("t4_rst_count", bus.blk_count, 0);
    chk("t4_rst_blk",   bus.out_block, 0);
    tick(); tick();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) ov_seen++;
    end
    chk("t4_no_result", 32'(ov_seen), 0);
    chk("t4_in_ready",  bus.in_ready, 1);
    chk("t4_count",     bus.blk_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
